leds7_cmd_arbiter: RTL and testbench

Round-robin arbiter and command sequencer that shares the seven-segment display command channel among several requesters. Each requester asks to set one digit (index 0-3) to a 4-bit value. The block grants one request at a time and serializes it into the two-byte command stream accepted by the display controller: a select byte `0xF0+index`, then a value byte `0x0?`. It sits between the internal requesters (counters, status logic, UART receive path) and either the display controller's byte input or a UART transmitter.

---
 rtl/leds7_cmd_arbiter_if.sv | 40 ++++
 rtl/leds7_cmd_arbiter.sv | 137 +++++++++++++
 tb/tb_leds7_cmd_arbiter.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/leds7_cmd_arbiter_if.sv
// Bundle of requester-side and display-side signals for leds7_cmd_arbiter.
//   req_valid/req_led/req_value : per-requester digit update requests
//   req_ready                   : one-hot grant, combinational in IDLE
//   out_data/out_valid/out_ready: serialized command byte stream
//   busy                        : arbiter is not in IDLE
// The master modport is the arbiter; slave is the requesters plus downstream sink.
interface leds7_cmd_arbiter_if #(
  parameter int unsigned N_REQ = 4
);
  logic [N_REQ-1:0]   req_valid;
  logic [2*N_REQ-1:0] req_led;
  logic [4*N_REQ-1:0] req_value;
  logic [N_REQ-1:0]   req_ready;
  logic [7:0]         out_data;
  logic               out_valid;
  logic               out_ready;
  logic               busy;

  modport master (
    input  req_valid,
    input  req_led,
    input  req_value,
    output req_ready,
    output out_data,
    output out_valid,
    input  out_ready,
    output busy
  );

  modport slave (
    output req_valid,
    output req_led,
    output req_value,
    input  req_ready,
    input  out_data,
    input  out_valid,
    output out_ready,
    input  busy
  );
endinterface

// File: rtl/leds7_cmd_arbiter.sv
// Round-robin arbiter that serializes digit updates from N_REQ requesters
// into the two-byte display command stream: 0xF0+index, then 0x00+value.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : leds7_cmd_arbiter_if master modport (requests in, bytes out)
// Parameters: N_REQ (2-8 requesters), GAP_CYCLES (0-255 idle cycles after a pair).
module leds7_cmd_arbiter #(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic                clk,
  input  logic                reset,
  leds7_cmd_arbiter_if.master bus
);

  localparam int unsigned IDX_W = $clog2(N_REQ);
  localparam int unsigned GAP_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEL  = 2'd1,
    ST_VAL  = 2'd2,
    ST_GAP  = 2'd3
  } state_e;

  state_e             state_q;
  logic [IDX_W-1:0]   last_grant_q;
  logic [3:0]         value_q;
  logic               out_valid_q;
  logic [7:0]         out_data_q;
  logic               busy_q;
  logic [GAP_W-1:0]   gap_q;

  logic [1:0]         led_arr_c [N_REQ];
  logic [3:0]         val_arr_c [N_REQ];
  logic               grant_found_c;
  logic [IDX_W-1:0]   grant_idx_c;
  logic [IDX_W-1:0]   cand_c;
  logic [N_REQ-1:0]   req_ready_c;

  // Split the flat request buses into per-requester fields.
  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      led_arr_c[i] = bus.req_led[2*i +: 2];
      val_arr_c[i] = bus.req_value[4*i +: 4];
    end
  end

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    grant_found_c = 1'b0;
    grant_idx_c   = '0;
    cand_c        = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand_c = IDX_W'((32'(last_grant_q) + k) % N_REQ);
      if (!grant_found_c && bus.req_valid[cand_c]) begin
        grant_found_c = 1'b1;
        grant_idx_c   = cand_c;
      end
    end
  end

  // Grant is combinational so a requester sees acceptance in the IDLE cycle;
  // gated by reset so nothing is granted while reset is held.
  always_comb begin
    req_ready_c = '0;
    if (state_q == ST_IDLE && grant_found_c && !reset) begin
      req_ready_c = N_REQ'(1) << grant_idx_c;
    end
  end

  // Sequencer with registered byte stream outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= IDX_W'(N_REQ - 1);
      value_q      <= 4'h0;
      out_valid_q  <= 1'b0;
      out_data_q   <= 8'h00;
      busy_q       <= 1'b0;
      gap_q        <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant_found_c) begin
            last_grant_q <= grant_idx_c;
            value_q      <= val_arr_c[grant_idx_c];
            out_valid_q  <= 1'b1;
            out_data_q   <= {4'hF, 2'b00, led_arr_c[grant_idx_c]};
            busy_q       <= 1'b1;
            state_q      <= ST_SEL;
          end
        end
        ST_SEL: begin
          if (bus.out_ready) begin
            out_data_q <= {4'h0, value_q};
            state_q    <= ST_VAL;
          end
        end
        ST_VAL: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            if (GAP_CYCLES == 0) begin
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end else begin
              gap_q   <= GAP_W'(GAP_CYCLES - 1);
              state_q <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          // Leave in the cycle the counter reads zero.
          if (gap_q == '0) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            gap_q <= gap_q - GAP_W'(1);
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          out_valid_q <= 1'b0;
          out_data_q  <= 8'h00;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_leds7_cmd_arbiter.sv
// Directed self-checking bench for leds7_cmd_arbiter (GAP_CYCLES 0 and 5 instances).
module tb_leds7_cmd_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  leds7_cmd_arbiter_if #(.N_REQ(4)) bus0 ();
  leds7_cmd_arbiter_if #(.N_REQ(4)) bus5 ();

  leds7_cmd_arbiter #(.N_REQ(4), .GAP_CYCLES(0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  leds7_cmd_arbiter #(.N_REQ(4), .GAP_CYCLES(5)) dut5 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus5)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Minimal display controller: select byte picks a digit, next value byte writes it.
  logic [3:0] disp [4];
  int         pulses [4];
  logic       pend;
  logic [1:0] sel;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        disp[i]   <= 4'h0;
        pulses[i] <= 0;
      end
      pend <= 1'b0;
      sel  <= 2'd0;
    end else if (bus0.out_valid && bus0.out_ready) begin
      if (bus0.out_data[7:4] == 4'hF) begin
        sel  <= bus0.out_data[1:0];
        pend <= 1'b1;
      end else if (pend) begin
        disp[sel]   <= bus0.out_data[3:0];
        pulses[sel] <= pulses[sel] + 1;
        pend        <= 1'b0;
      end
    end
  end

  initial begin
    logic [9:0] pat;
    logic [3:0] rr;
    int phase, xfers, gap, idle;
    logic hit;

    reset = 1'b1;
    bus0.req_valid = '0; bus0.req_led = '0; bus0.req_value = '0; bus0.out_ready = 1'b1;
    bus5.req_valid = '0; bus5.req_led = '0; bus5.req_value = '0; bus5.out_ready = 1'b1;
    #1;
    check("rst_valid", 32'(bus0.out_valid), 32'h0);
    check("rst_data",  32'(bus0.out_data),  32'h00);
    check("rst_busy",  32'(bus0.busy),      32'h0);
    tick(); tick();

    // Single request from requester 2: led 1, value 7.
    reset = 1'b0;
    bus0.req_valid = 4'b0100;
    bus0.req_led   = 8'b00_01_00_00;
    bus0.req_value = 16'h0700;
    #1;
    check("t1_ready_T", 32'(bus0.req_ready), 32'h4);
    check("t1_busy_T",  32'(bus0.busy),      32'h0);
    tick();
    bus0.req_valid = '0;
    check("t1_sel",       32'(bus0.out_data),  32'hF1);
    check("t1_sel_valid", 32'(bus0.out_valid), 32'h1);
    check("t1_busy_T1",   32'(bus0.busy),      32'h1);
    check("t1_ready_T1",  32'(bus0.req_ready), 32'h0);
    tick();
    check("t1_val",       32'(bus0.out_data),  32'h07);
    check("t1_val_valid", 32'(bus0.out_valid), 32'h1);
    tick();
    check("t1_busy_T3",  32'(bus0.busy),      32'h0);
    check("t1_idle_vld", 32'(bus0.out_valid), 32'h0);
    check("t1_idle_dat", 32'(bus0.out_data),  32'h00);

    // All four requesters continuously valid: strict rotation, 3 cycles per grant.
    reset = 1'b1; #1; reset = 1'b0;
    tick();
    bus0.req_valid = 4'b1111;
    bus0.req_led   = 8'b11_10_01_00;
    bus0.req_value = 16'hDCBA;
    for (int g = 0; g < 8; g++) begin
      #1;
      check("t2_grant", 32'(bus0.req_ready), 32'(1) << (g % 4));
      tick();
      check("t2_sel", 32'(bus0.out_data), 32'hF0 + 32'(g % 4));
      tick();
      check("t2_val", 32'(bus0.out_data), 32'h0A + 32'(g % 4));
      tick();
    end
    bus0.req_valid = '0;

    // Backpressure on requester 1 with led 3 / value F.
    bus0.req_valid = 4'b0010;
    bus0.req_led   = 8'b00_00_11_00;
    bus0.req_value = 16'h00F0;
    #1;
    check("t3_grant", 32'(bus0.req_ready), 32'h2);
    tick();
    bus0.req_valid = '0;
    pat = 10'b00_0100_0100;
    phase = 0;
    xfers = 0;
    for (int c = 0; c < 10; c++) begin
      bus0.out_ready = pat[c];
      #1;
      check("t3_valid", 32'(bus0.out_valid), (phase < 2) ? 32'h1 : 32'h0);
      check("t3_data",  32'(bus0.out_data),
            (phase == 0) ? 32'hF3 : (phase == 1) ? 32'h0F : 32'h00);
      if (bus0.out_valid && bus0.out_ready) begin
        xfers++;
        phase++;
      end
      tick();
    end
    check("t3_xfers", 32'(xfers), 32'd2);
    bus0.out_ready = 1'b1;

    // Reset while stalled in VAL; then requester 0 beats requester 3.
    bus0.req_valid = 4'b0001;
    bus0.req_led   = 8'b00_00_00_10;
    bus0.req_value = 16'h0005;
    #1;
    check("t5_grant", 32'(bus0.req_ready), 32'h1);
    tick();
    bus0.req_valid = '0;
    check("t5_sel", 32'(bus0.out_data), 32'hF2);
    tick();
    bus0.out_ready = 1'b0;
    check("t5_val", 32'(bus0.out_data), 32'h05);
    tick();
    check("t5_val_hold", 32'(bus0.out_data), 32'h05);
    bus0.req_valid = 4'b1001;
    bus0.req_led   = 8'b11_00_00_00;
    bus0.req_value = 16'h0000;
    #2;
    reset = 1'b1;
    #1;
    check("t5_rst_valid", 32'(bus0.out_valid), 32'h0);
    check("t5_rst_data",  32'(bus0.out_data),  32'h00);
    check("t5_rst_busy",  32'(bus0.busy),      32'h0);
    check("t5_rst_ready", 32'(bus0.req_ready), 32'h0);
    tick(); tick();
    reset = 1'b0;
    bus0.out_ready = 1'b1;
    #1;
    check("t5_tie_r0", 32'(bus0.req_ready), 32'h1);
    tick();
    bus0.req_valid = 4'b1000;
    check("t5_sel0", 32'(bus0.out_data), 32'hF0);
    tick();
    tick();
    #1;
    check("t5_then_r3", 32'(bus0.req_ready), 32'h8);
    tick();
    bus0.req_valid = '0;
    check("t5_sel3", 32'(bus0.out_data), 32'hF3);
    tick(); tick();

    // GAP_CYCLES = 5 instance with back-to-back requests from 0 and 1.
    bus5.req_valid = 4'b0011;
    bus5.req_led   = 8'b00_00_10_01;
    bus5.req_value = 16'h0043;
    #1;
    check("t6_grant0", 32'(bus5.req_ready), 32'h1);
    tick();
    bus5.req_valid = 4'b0010;
    check("t6_sel0", 32'(bus5.out_data), 32'hF1);
    tick();
    check("t6_val0", 32'(bus5.out_data), 32'h03);
    gap = 0;
    idle = 0;
    rr = '0;
    hit = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus5.out_valid) begin
        hit = 1'b1;
        break;
      end else if (bus5.busy) begin
        gap++;
      end else begin
        idle++;
        rr = bus5.req_ready;
      end
    end
    bus5.req_valid = '0;
    check("t6_resumed",   32'(hit),  32'h1);
    check("t6_gap_busy",  32'(gap),  32'd5);
    check("t6_idle",      32'(idle), 32'd1);
    check("t6_grant1",    32'(rr),   32'h2);
    check("t6_sel1",      32'(bus5.out_data), 32'hF2);

    // Four digits through the display controller model, one requester each.
    reset = 1'b1; #1; reset = 1'b0;
    tick();
    bus0.req_led   = 8'b00_01_10_11;
    bus0.req_value = 16'h1234;
    bus0.req_valid = 4'b1111;
    hit = 1'b0;
    for (int c = 0; c < 40; c++) begin
      #1;
      rr = bus0.req_ready;
      tick();
      bus0.req_valid = bus0.req_valid & ~rr;
      if (bus0.req_valid == '0 && !bus0.busy) begin
        hit = 1'b1;
        break;
      end
    end
    check("t7_done", 32'(hit), 32'h1);
    for (int i = 0; i < 4; i++) begin
      check("t7_digit", 32'(disp[i]), 32'(i + 1));
      check("t7_pulses", 32'(pulses[i]), 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
